// File: rtl/gstep_seq_pkg.sv
// Shared definitions for the Gouraud/Z span stepper: state encoding and
// default widths used by the stepper and its adder.
package gstep_seq_pkg;

    localparam int DATA_W    = 16;
    localparam int CNT_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gstep_state_t;

endpackage

// File: rtl/gstep_seq_add16sat.sv
// 16-bit adder with optional saturation and an 8-bit lane mode, shared by the
// blitter add array. satd flags any step whose result was clamped.
module add16sat
    import gstep_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              sat,
    input  logic              eightbit,
    input  logic              hicinh,
    output logic [DATA_W-1:0] q,
    output logic              co,
    output logic              satd
);

    // Overflow is detected when the carry out disagrees with the sign of b:
    // a positive step that carried wrapped high, a negative step that did not carry wrapped low.
    function automatic logic [7:0] sat_byte(input logic [7:0] sum, input logic carry,
                                            input logic bsign, input logic sat_en);
        if (sat_en && (carry != bsign))
            return carry ? 8'hFF : 8'h00;
        return sum;
    endfunction

    function automatic logic [DATA_W-1:0] sat_word(input logic [DATA_W-1:0] sum, input logic carry,
                                                   input logic bsign, input logic sat_en);
        if (sat_en && (carry != bsign))
            return carry ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        return sum;
    endfunction

    logic [8:0] w_lo;
    logic [8:0] w_hi;
    logic       w_hicin;
    logic       w_ovf_lo;
    logic       w_ovf_word;

    assign w_lo       = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
    // In 8-bit mode the lanes are independent, so no carry crosses into the high byte.
    assign w_hicin    = w_lo[8] & ~eightbit & ~hicinh;
    assign w_hi       = {1'b0, a[15:8]} + {1'b0, b[15:8]} + {8'd0, w_hicin};
    assign w_ovf_lo   = sat & (w_lo[8] != b[7]);
    assign w_ovf_word = sat & (w_hi[8] != b[15]);
    assign co         = w_hi[8];

    always_comb begin
        q    = {w_hi[7:0], w_lo[7:0]};
        satd = 1'b0;
        if (eightbit) begin
            q[7:0] = sat_byte(w_lo[7:0], w_lo[8], b[7], sat);
            satd   = w_ovf_lo;
        end else begin
            q    = sat_word({w_hi[7:0], w_lo[7:0]}, w_hi[8], b[15], sat);
            satd = w_ovf_word;
        end
    end

endmodule

// File: rtl/gstep_seq.sv
// Gouraud/Z span stepper: loads a start value and emits one value per accepted
// pixel, stepping by a signed increment through add16sat.
module gstep_seq
    import gstep_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              start,
    input  logic [DATA_W-1:0] init,
    input  logic [DATA_W-1:0] inc,
    input  logic [CNT_W-1:0]  count,
    input  logic              sat,
    input  logic              eightbit,
    input  logic              abort,
    output logic              busy,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              done,
    output logic              clamped
);

    gstep_state_t             r_state;
    gstep_state_t             w_next;
    logic [DATA_W-1:0]        r_acc;
    logic signed [DATA_W-1:0] r_inc;
    logic [CNT_W-1:0]         r_rem;
    logic                     r_sat;
    logic                     r_eightbit;
    logic                     r_clamped;
    logic                     w_start_ok;
    logic                     w_xfer;
    logic                     w_last;
    logic [DATA_W-1:0]        w_sum;
    logic                     w_step_sat;
    logic                     w_unused_co;

    assign w_start_ok = (r_state == IDLE) && start && (count != '0);
    // pix_valid is high for the whole of RUN, so ready alone completes a transfer there.
    assign w_xfer     = (r_state == RUN) && pix_ready;
    assign w_last     = (r_rem == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetl)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start)
                    w_next = (count != '0) ? RUN : DONE;
            end
            RUN: begin
                if (abort)
                    w_next = IDLE;
                else if (w_xfer && w_last)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        pix_valid = 1'b0;
        done      = 1'b0;
        case (r_state)
            RUN: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator, remaining count and sticky clamp flag.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_clamped <= 1'b0;
        end else if (w_start_ok) begin
            r_acc     <= init;
            r_rem     <= count;
            r_clamped <= 1'b0;
        end else if (w_xfer && !abort) begin
            // The step after the last pixel is never shown, but its saturation still counts.
            if (!w_last)
                r_acc <= w_sum;
            r_rem     <= r_rem - CNT_W'(1);
            r_clamped <= r_clamped | w_step_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_inc      <= inc;
            r_sat      <= sat;
            r_eightbit <= eightbit;
        end
    end

    add16sat u_add (
        .a        (r_acc),
        .b        (r_inc),
        .cin      (1'b0),
        .sat      (r_sat),
        .eightbit (r_eightbit),
        .hicinh   (1'b0),
        .q        (w_sum),
        .co       (w_unused_co),
        .satd     (w_step_sat)
    );

    assign pix_data = r_acc;
    assign clamped  = r_clamped;

endmodule

// File: tb/tb_gstep_seq.sv
// Directed bench for gstep_seq: a queue-based pixel model checked every cycle,
// plus hand-computed pixel sequences for the key spans.
module tb_gstep_seq;

    logic        clk = 1'b0;
    logic        resetl;
    logic        start;
    logic [15:0] init;
    logic [15:0] inc;
    logic [11:0] count;
    logic        sat;
    logic        eightbit;
    logic        abort;
    logic        busy;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        done;
    logic        clamped;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;
    int n_xfer, n_done, n_valid, n_stall, done_cyc, last_xfer_cyc;
    logic [15:0] stall_data;
    logic [15:0] exp_q[$];
    bit          exp_f_q[$];
    logic [15:0] got_q[$];
    logic [15:0] lit_q[$];
    bit          model_clamped = 1'b0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    gstep_seq #(.CNT_W(12)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .start     (start),
        .init      (init),
        .inc       (inc),
        .count     (count),
        .sat       (sat),
        .eightbit  (eightbit),
        .abort     (abort),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .done      (done),
        .clamped   (clamped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // One pixel step from the arithmetic rules: returns {saturated, result}.
    function automatic logic [16:0] model_step(input logic [15:0] a, input logic [15:0] b,
                                               input bit s, input bit e);
        int sum, lo, hi;
        bit c, f;
        logic [15:0] r;
        f = 1'b0;
        if (!e) begin
            sum = int'(a) + int'(b);
            c   = (sum > 65535);
            r   = 16'(sum % 65536);
            if (s && (c != b[15])) begin
                r = c ? 16'hFFFF : 16'h0000;
                f = 1'b1;
            end
        end else begin
            lo = int'(a[7:0]) + int'(b[7:0]);
            hi = (int'(a[15:8]) + int'(b[15:8])) % 256;
            c  = (lo > 255);
            lo = lo % 256;
            if (s && (c != b[7])) begin
                lo = c ? 255 : 0;
                f  = 1'b1;
            end
            r = {8'(hi), 8'(lo)};
        end
        return {f, r};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            cyc_n++;
            check("busy_state", busy, pix_valid | done);
            if (done) begin
                n_done++;
                done_cyc = cyc_n;
                check("valid_in_done", pix_valid, 1'b0);
            end
            if (busy)
                check("clamped", clamped, model_clamped);
            if (pix_valid) begin
                n_valid++;
                if (!pix_ready) begin
                    n_stall++;
                    stall_data = pix_data;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pix_unexpected: got pixel 0x%0h, expected none (cycle %0d)", pix_data, cyc_n);
                end else begin
                    check("pix_data", pix_data, exp_q[0]);
                    if (pix_ready) begin
                        got_q.push_back(pix_data);
                        model_clamped = model_clamped | exp_f_q[0];
                        void'(exp_q.pop_front());
                        void'(exp_f_q.pop_front());
                        n_xfer++;
                        last_xfer_cyc = cyc_n;
                    end
                end
            end
        end
    end

    task automatic check_seq(input string name);
        check({name, "_len"}, got_q.size(), lit_q.size());
        for (int k = 0; k < lit_q.size() && k < got_q.size(); k++)
            check(name, got_q[k], lit_q[k]);
    endtask

    task automatic run_span(input logic [15:0] s_init, input logic [15:0] s_inc,
                            input logic [11:0] s_cnt, input bit s_sat, input bit s_eb,
                            input int stall_after, input int stall_len,
                            input int abort_after, input int reset_after,
                            input bit abort_at_start);
        logic [15:0] acc;
        logic [16:0] r;
        int stalled = 0;
        int ev = 0;
        bit ended = 1'b0;
        exp_q.delete();
        exp_f_q.delete();
        acc = s_init;
        for (int k = 0; k < int'(s_cnt); k++) begin
            r = model_step(acc, s_inc, s_sat, s_eb);
            exp_q.push_back(acc);
            exp_f_q.push_back(r[16]);
            acc = r[15:0];
        end
        got_q.delete();
        n_xfer = 0; n_done = 0; n_valid = 0; n_stall = 0;
        done_cyc = -1; last_xfer_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; init = s_init; inc = s_inc; count = s_cnt;
        sat = s_sat; eightbit = s_eb; pix_ready = 1'b1;
        abort = abort_at_start;
        if (s_cnt != 0)
            model_clamped = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < int'(s_cnt) + 50 && !ended; c++) begin
            start = 1'b0; abort = 1'b0; resetl = 1'b1; pix_ready = 1'b1;
            if (abort_after >= 0 && n_xfer == abort_after) begin
                abort = 1'b1; pix_ready = 1'b0; ev = 1;
            end else if (reset_after >= 0 && n_xfer == reset_after) begin
                resetl = 1'b0; pix_ready = 1'b0; ev = 2;
            end else if (stall_after >= 0 && n_xfer == stall_after && stalled < stall_len) begin
                pix_ready = 1'b0;
                stalled++;
                if (stalled == 2) begin
                    start = 1'b1; init = 16'hDEAD; inc = 16'h7777; count = 12'd9;
                end
            end
            @(posedge clk); #1;
            if (ev != 0) begin
                ended = 1'b1;
                exp_q.delete();
                exp_f_q.delete();
                if (ev == 2)
                    model_clamped = 1'b0;
            end
            if (n_done > 0)
                ended = 1'b1;
        end
        start = 1'b0; abort = 1'b0; resetl = 1'b1; pix_ready = 1'b1;
        if (!ended) begin
            n_checks++;
            n_errors++;
            $display("FAIL span_timeout: got no span end, expected done/abort/reset");
        end
        @(negedge clk); #1;
        check("end_busy", busy, 1'b0);
        check("end_valid", pix_valid, 1'b0);
        check("end_done", done, 1'b0);
        if (ev == 0) begin
            check("done_count", n_done, 1);
            check("xfer_count", n_xfer, int'(s_cnt));
            check("model_drained", exp_q.size(), 0);
            if (s_cnt != 0)
                check("done_latency", done_cyc, last_xfer_cyc + 1);
            else
                check("zero_no_valid", n_valid, 0);
        end else begin
            if (ev == 2) begin
                check("rst_pix_data", pix_data, 16'h0000);
                check("rst_clamped", clamped, 1'b0);
            end
            repeat (3) @(negedge clk);
            #1;
            check("cancel_no_done", n_done, 0);
            check("cancel_xfers", n_xfer, ev == 1 ? abort_after : reset_after);
        end
    endtask

    initial begin
        resetl = 1'b0; start = 1'b0; init = '0; inc = '0; count = '0;
        sat = 1'b0; eightbit = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_busy", busy, 1'b0);
        check("reset_valid", pix_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_clamped", clamped, 1'b0);
        check("reset_pix_data", pix_data, 16'h0000);
        mon_en = 1'b1;
        @(posedge clk); #1;
        resetl = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;

        run_span(16'h1000, 16'h0100, 12'd4, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        lit_q = '{16'h1000, 16'h1100, 16'h1200, 16'h1300};
        check_seq("ramp16");
        check("ramp16_clamped", clamped, 1'b0);

        run_span(16'hFF00, 16'h0080, 12'd3, 1'b1, 1'b0, -1, 0, -1, -1, 1'b1);
        lit_q = '{16'hFF00, 16'hFF80, 16'hFFFF};
        check_seq("sat_high");
        check("sat_high_clamped", clamped, 1'b1);

        run_span(16'h0100, 16'hFF80, 12'd4, 1'b1, 1'b0, -1, 0, -1, -1, 1'b0);
        lit_q = '{16'h0100, 16'h0080, 16'h0000, 16'h0000};
        check_seq("sat_low");
        check("sat_low_clamped", clamped, 1'b1);

        run_span(16'h12F0, 16'h0108, 12'd3, 1'b1, 1'b1, -1, 0, -1, -1, 1'b0);
        lit_q = '{16'h12F0, 16'h13F8, 16'h14FF};
        check_seq("lane8");
        check("lane8_clamped", clamped, 1'b1);

        run_span(16'h0200, 16'h0010, 12'd4, 1'b0, 1'b0, 1, 3, -1, -1, 1'b0);
        lit_q = '{16'h0200, 16'h0210, 16'h0220, 16'h0230};
        check_seq("stall");
        check("stall_cycles", n_stall, 3);
        check("stall_held", stall_data, 16'h0210);

        run_span(16'hFFF0, 16'h0020, 12'd6, 1'b1, 1'b0, -1, 0, 2, -1, 1'b0);
        lit_q = '{16'hFFF0, 16'hFFFF};
        check_seq("abort");
        check("abort_clamped_held", clamped, 1'b1);

        run_span(16'h4321, 16'h0001, 12'd0, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        check("zero_clamped_held", clamped, 1'b1);

        run_span(16'h0500, 16'h0001, 12'd8, 1'b0, 1'b0, -1, 0, -1, 3, 1'b0);

        run_span(16'h0A00, 16'hFFFF, 12'd3, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        lit_q = '{16'h0A00, 16'h09FF, 16'h09FE};
        check_seq("after_reset");

        run_span(16'h0000, 16'h0001, 12'hFFF, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        if (got_q.size() > 0)
            check("long_last", got_q[got_q.size()-1], 16'h0FFE);
        else
            check("long_last", 32'hFFFF_FFFF, 16'h0FFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
